// File: rtl/multdiv_seq.sv
// Decode-stage sequencer for an external multiply/divide unit: issues the start pulse, stalls
// decode, and writes the result back. Define MULTDIV_EXC_EN to redirect exception writes to r30.
module multdiv_seq #(
   parameter int TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  op,
   input  logic [4:0]  func,
   input  logic [4:0]  rd,
   input  logic        md_resultRDY,
   input  logic        md_exception,
   input  logic [31:0] md_result,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic [3:0]  dbg
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [4:0]    rd_q;
   logic          div_q;
   logic [31:0]   res_q;
   logic          exc_q;

   logic is_mul, is_div, is_md, timeout, finish;
   logic [31:0] res_nxt;
   logic        exc_nxt;

   assign is_mul = (op == 5'b00000) && (func == 5'b00110);
   assign is_div = (op == 5'b00000) && (func == 5'b00111);
   assign is_md  = is_mul | is_div;

   // A result arriving on the timeout cycle is taken from the unit, not treated as an abort.
   assign timeout = (cnt == CW'(TIMEOUT - 1));
   assign finish  = md_resultRDY | timeout;
   assign res_nxt = md_resultRDY ? md_result : 32'd0;
   assign exc_nxt = md_resultRDY ? md_exception : 1'b1;

   assign ctrl_MULT = (state == IDLE) & is_mul & ~reset;
   assign ctrl_DIV  = (state == IDLE) & is_div & ~reset;
   assign stall     = ((state == IDLE) & is_md) | (state == BUSY);
   assign dbg       = {state, div_q, exc_q};

   always_comb begin
      wb_en   = 1'b0;
      wb_reg  = 5'd0;
      wb_data = 32'd0;
      if (state == DONE) begin
`ifdef MULTDIV_EXC_EN
         if (exc_q) begin
            wb_en   = 1'b1;
            wb_reg  = 5'd30;
            wb_data = div_q ? 32'd5 : 32'd4;
         end else begin
            wb_en   = (rd_q != 5'd0);
            wb_reg  = rd_q;
            wb_data = res_q;
         end
`else
         wb_en   = (rd_q != 5'd0);
         wb_reg  = rd_q;
         wb_data = res_q;
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         rd_q  <= 5'd0;
         div_q <= 1'b0;
         res_q <= 32'd0;
         exc_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (is_md) begin
                  rd_q  <= rd;
                  div_q <= is_div;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (finish) begin
                  res_q <= res_nxt;
                  exc_q <= exc_nxt;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: directed and random multiply/divide transactions compared against a
// transaction-level model of stall length, start pulses and the single writeback.
module tb_multdiv_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  op, func, rd;
   logic        md_resultRDY, md_exception;
   logic [31:0] md_result;
   logic        ctrl_MULT, ctrl_DIV, stall, wb_en;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic [3:0]  dbg;

   int total = 0;
   int bad   = 0;

   multdiv_seq #(.TIMEOUT(40)) dut (
      .clock(clock), .reset(reset), .op(op), .func(func), .rd(rd),
      .md_resultRDY(md_resultRDY), .md_exception(md_exception), .md_result(md_result),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .dbg(dbg)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_non_md();
      op   = 5'($urandom_range(0, 31));
      func = 5'($urandom_range(0, 31));
      if (op == 5'd0 && (func == 5'd6 || func == 5'd7)) func = 5'd0;
      rd           = 5'($urandom_range(0, 31));
      md_resultRDY = 1'($urandom_range(0, 1));
      md_exception = 1'($urandom_range(0, 1));
      md_result    = $urandom;
   endtask

   // One instruction held in decode; lat = BUSY cycle on which RDY pulses (0 = never).
   task automatic run_op(input bit is_div, input logic [4:0] r, input int lat,
                         input logic [31:0] res, input logic exc);
      bit          tmo;
      int          busy, stalls, mp, dp, wbs, done_c;
      logic        ef, exp_en, obs_en;
      logic [4:0]  exp_reg, obs_reg;
      logic [31:0] exp_data, obs_data;
      tmo  = !(lat >= 1 && lat <= 40);
      busy = tmo ? 40 : lat;
      ef   = tmo ? 1'b1 : exc;
      exp_en   = (r != 5'd0);
      exp_reg  = r;
      exp_data = tmo ? 32'd0 : res;
`ifdef MULTDIV_EXC_EN
      if (ef) begin
         exp_en   = 1'b1;
         exp_reg  = 5'd30;
         exp_data = is_div ? 32'd5 : 32'd4;
      end
`else
      ef = ef;
`endif
      stalls = 0; mp = 0; dp = 0; wbs = 0; done_c = -1;
      obs_en = 1'b0; obs_reg = 5'd0; obs_data = 32'd0;
      for (int c = 0; c < 60 && done_c < 0; c++) begin
         @(negedge clock);
         op   = 5'd0;
         func = is_div ? 5'd7 : 5'd6;
         rd   = r;
         md_resultRDY = (lat > 0 && c == lat);
         md_result    = md_resultRDY ? res : $urandom;
         md_exception = md_resultRDY ? exc : 1'($urandom_range(0, 1));
         #1;
         stalls += int'(stall);
         mp     += int'(ctrl_MULT);
         dp     += int'(ctrl_DIV);
         wbs    += int'(wb_en);
         if (c > 0 && !stall) begin
            done_c   = c;
            obs_en   = wb_en;
            obs_reg  = wb_reg;
            obs_data = wb_data;
         end
      end
      chk("done_reached", 32'(done_c >= 0), 32'd1);
      chk("stall_cycles", 32'(stalls), 32'(busy + 1));
      chk("done_cycle", 32'(done_c), 32'(busy + 1));
      chk("mult_pulses", 32'(mp), is_div ? 32'd0 : 32'd1);
      chk("div_pulses", 32'(dp), is_div ? 32'd1 : 32'd0);
      chk("wb_pulses", 32'(wbs), 32'(exp_en));
      chk("wb_en", 32'(obs_en), 32'(exp_en));
      chk("wb_reg", 32'(obs_reg), 32'(exp_reg));
      if (exp_en) chk("wb_data", obs_data, exp_data);
      @(negedge clock);
      drive_non_md();
      #1;
      chk("post_stall", 32'(stall), 32'd0);
      chk("post_wb_en", 32'(wb_en), 32'd0);
      chk("post_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      op = 5'd0; func = 5'd0; rd = 5'd0;
      md_resultRDY = 1'b0; md_exception = 1'b0; md_result = 32'd0;
      #3;
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_wb_reg", 32'(wb_reg), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_stall_idle", 32'(stall), 32'd0);
      func = 5'd6;
      #1;
      chk("rst_stall_md", 32'(stall), 32'd1);
      chk("rst_ctrl_mult", 32'(ctrl_MULT), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      func  = 5'd0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         drive_non_md();
         #1;
         chk("idle_stall", 32'(stall), 32'd0);
         chk("idle_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
         chk("idle_wb_en", 32'(wb_en), 32'd0);
      end

      run_op(1'b0, 5'd3, 5, 32'h0000_0042, 1'b0);
      run_op(1'b1, 5'd7, 3, 32'hDEAD_BEEF, 1'b1);
      run_op(1'b0, 5'd0, 4, 32'h1234_5678, 1'b0);
      run_op(1'b1, 5'd5, 0, 32'h0, 1'b0);
      run_op(1'b0, 5'd9, 40, 32'hCAFE_0001, 1'b0);
      run_op(1'b1, 5'd0, 1, 32'h0BAD_F00D, 1'b1);

      // Reset lands in the third BUSY cycle of a multiply.
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         op = 5'd0; func = 5'd6; rd = 5'd11; md_resultRDY = 1'b0;
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("mid_rst_stall", 32'(stall), 32'd1);
      chk("mid_rst_ctrl", 32'(ctrl_MULT), 32'd0);
      chk("mid_rst_wb_en", 32'(wb_en), 32'd0);
      func = 5'd0;
      #1;
      chk("mid_rst_idle", 32'(stall), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         op = 5'd0; func = 5'd0; md_resultRDY = 1'b1; md_result = $urandom;
         #1;
         chk("after_rst_wb_en", 32'(wb_en), 32'd0);
         chk("after_rst_stall", 32'(stall), 32'd0);
      end
      run_op(1'b0, 5'd11, 2, 32'h0000_0777, 1'b0);
      run_op(1'b0, 5'd12, 3, 32'h0000_0888, 1'b0);

      for (int i = 0; i < 12; i++) begin
         run_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                int'($urandom_range(0, 45)), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter: TIMEOUT, 40, max BUSY cycles waiting for md_resultRDY before abort.
REQ-002 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: op  in  5  opcode of instruction in decode.
REQ-005 Port: func  in  5  ALU func field of instruction in decode.
REQ-006 Port: rd  in  5  destination register of instruction in decode.
REQ-007 Port: md_resultRDY  in  1  multdiv unit result-valid pulse.
REQ-008 Port: md_exception  in  1  multdiv overflow / divide-by-zero flag, qualified by md_resultRDY.
REQ-009 Port: md_result  in  32  multdiv result, qualified by md_resultRDY.
REQ-010 Port: ctrl_MULT  out  1  one-cycle multiply start pulse to multdiv unit.
REQ-011 Port: ctrl_DIV  out  1  one-cycle divide start pulse to multdiv unit.
REQ-012 Port: stall  out  1  holds PC and decode instruction when high.
REQ-013 Port: wb_en  out  1  register-file write enable for multdiv result.
REQ-014 Port: wb_reg  out  5  register-file write address.
REQ-015 Port: wb_data  out  32  register-file write data.

Function
REQ-016 Decode: is_mul = (op==00000 & func==00110); is_div = (op==00000 & func==00111); is_md = is_mul | is_div.
REQ-017 FSM states IDLE, BUSY, DONE; one-hot or binary, encoding free.
REQ-018 IDLE & is_md: ctrl_MULT=is_mul or ctrl_DIV=is_div for that cycle only; latch rd into rd_q and is_div into div_q; clear counter; next state BUSY.
REQ-019 IDLE & !is_md: stay IDLE; ctrl_MULT=ctrl_DIV=0; md_resultRDY ignored.
REQ-020 stall = (IDLE & is_md) | BUSY, combinational; stall=0 in DONE so PC advances on edge ending DONE.
REQ-021 BUSY: counter increments each cycle; on md_resultRDY latch md_result into res_q, md_exception into exc_q, next DONE.
REQ-022 BUSY timeout: counter==TIMEOUT-1 and md_resultRDY=0 -> res_q=0, exc_q=1, next DONE.
REQ-023 md_resultRDY and timeout on same cycle: RDY wins; result and flag taken from unit.
REQ-024 DONE: lasts exactly one cycle; wb_en=1, wb_reg=rd_q, wb_data=res_q (subject to REQ-025, REQ-030); unconditional next IDLE, no re-issue even if is_md still high.
REQ-025 rd_q==0 and no exception write: wb_en=0 in DONE (r0 never written).
REQ-026 Outside DONE: wb_en=0, wb_reg=0, wb_data=0.
REQ-027 Issue-to-writeback latency: 1 (issue) + N (BUSY until RDY, N>=1) + 1 (DONE) cycles.
REQ-028 Counter width ceil(log2(TIMEOUT))+1 bits; never wraps (saturation impossible since timeout exits BUSY).

Reset
REQ-029 reset high: state=IDLE, counter=0, rd_q=0, div_q=0, res_q=0, exc_q=0 immediately; all outputs 0 except stall, which follows REQ-020 from IDLE (reset mid-BUSY aborts operation, no writeback).

Configuration
REQ-030 Macro MULTDIV_EXC_EN defined: DONE with exc_q=1 writes wb_reg=30, wb_data=4 (mul) or 5 (div), wb_en=1 regardless of rd_q.
REQ-031 MULTDIV_EXC_EN undefined: exc_q ignored; DONE writes res_q to rd_q per REQ-024/REQ-025 (timeout writes 0 to rd_q).

Verification
REQ-032 mul, rd=3, RDY after 5 BUSY cycles, result=0x0000_0042 -> ctrl_MULT 1 cycle, stall 6 cycles, DONE wb_en=1 wb_reg=3 wb_data=0x42.
REQ-033 div by zero, rd=7, RDY+exception after 3 cycles, MULTDIV_EXC_EN defined -> wb_reg=30 wb_data=5; undefined -> wb_reg=7 wb_data=md_result.
REQ-034 mul, rd=0, no exception -> full stall sequence, wb_en=0 in DONE.
REQ-035 div, RDY never asserted, TIMEOUT=40 -> stall 41 cycles, DONE after 40 BUSY cycles, exc path per REQ-030/REQ-031.
REQ-036 reset asserted in 3rd BUSY cycle -> state IDLE same cycle, wb_en never pulses; back-to-back mul after DONE reissues ctrl_MULT exactly once.
